// File: rtl/dff_div_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : dff_div_pipe_if
// Purpose  : Bundles the data/control signals of dff_div_pipe.
//            master = the logic that drives en/d and consumes the outputs.
//            slave  = the divider/pipeline block itself.
// Signals  : en      count enable (0 freezes divider and pipeline)
//            d       WIDTH-bit data, sampled on each tick
//            clk_out divided 50% square wave
//            tick    one-cycle strobe on the clk_out rising edge
//            q       last pipeline stage
//            q_valid high once DEPTH ticks have occurred since reset
// Revision : 1.0  initial release
// ============================================================================
interface dff_div_pipe_if #(
  parameter int WIDTH = 1
) ();

  logic             en;
  logic [WIDTH-1:0] d;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] q;
  logic             q_valid;

  modport master (
    output en,
    output d,
    input  clk_out,
    input  tick,
    input  q,
    input  q_valid
  );

  modport slave (
    input  en,
    input  d,
    output clk_out,
    output tick,
    output q,
    output q_valid
  );

endinterface
`default_nettype wire

// File: rtl/dff_div_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dff_div_pipe
// Purpose  : Divides clk_in down to an OUT_HZ square wave and samples a
//            WIDTH-bit input on each rising edge of that wave through a
//            DEPTH-stage register pipeline. Everything runs on clk_in with a
//            one-cycle enable; no derived clocks are created.
// Ports    : clk_in  system clock
//            rst     asynchronous, active-low reset
//            bus     dff_div_pipe_if.slave (en, d, clk_out, tick, q, q_valid)
// Params   : CLK_HZ input clock frequency, OUT_HZ output frequency,
//            WIDTH data width, DEPTH pipeline stages from d to q (>= 1)
// Revision : 1.0  initial release
// ============================================================================
module dff_div_pipe #(
  parameter int CLK_HZ = 100_000_000,
  parameter int OUT_HZ = 5,
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 1
) (
  input  wire logic     clk_in,
  input  wire logic     rst,
  dff_div_pipe_if.slave bus
);

  // Half period of clk_out, in clk_in cycles.
  localparam int HALF  = CLK_HZ / (2 * OUT_HZ);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int VLD_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [VLD_W-1:0] c_vld_full = VLD_W'(DEPTH);

  generate
    if (HALF < 1) begin : g_bad_half
      $error("dff_div_pipe: CLK_HZ/(2*OUT_HZ) must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("dff_div_pipe: DEPTH must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_tick;
  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [VLD_W-1:0] r_vld_cnt;

  logic             w_wrap;
  logic             w_rise;

  // A wrap only happens on an enabled cycle, so en=0 on the would-be wrap
  // edge simply delays it. w_rise marks the wrap that takes clk_out 0->1.
  assign w_wrap = bus.en && (r_cnt == c_cnt_last);
  assign w_rise = w_wrap && !r_clk_out;

  // Divider and tick strobe.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_rise;
      if (bus.en) begin
        if (w_wrap) begin
          r_cnt     <= '0;
          r_clk_out <= ~r_clk_out;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Pipeline shifts on the same edge clk_out rises, so q updates together
  // with clk_out exactly like a flop clocked by clk_out would.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_rise) begin
      r_stage[0] <= bus.d;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  // Tick counter saturates at DEPTH; once full the pipeline holds real data.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_vld_cnt <= '0;
    end else if (w_rise && (r_vld_cnt != c_vld_full)) begin
      r_vld_cnt <= r_vld_cnt + 1'b1;
    end
  end

  assign bus.clk_out = r_clk_out;
  assign bus.tick    = r_tick;
  assign bus.q       = r_stage[DEPTH-1];
  assign bus.q_valid = (r_vld_cnt == c_vld_full);

endmodule
`default_nettype wire

// File: tb/tb_dff_div_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_div_pipe
// Purpose  : Self-checking bench for dff_div_pipe.
//            dut_a: CLK_HZ=100, OUT_HZ=5 (HALF=10), WIDTH=4, DEPTH=3
//            dut_b: CLK_HZ=10,  OUT_HZ=5 (HALF=1),  WIDTH=4, DEPTH=1
// Revision : 1.0  initial release
// ============================================================================
module tb_dff_div_pipe;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_run;
  int n_fail;

  dff_div_pipe_if #(.WIDTH(4)) bus_a ();
  dff_div_pipe_if #(.WIDTH(4)) bus_b ();

  dff_div_pipe #(
    .CLK_HZ (100),
    .OUT_HZ (5),
    .WIDTH  (4),
    .DEPTH  (3)
  ) dut_a (
    .clk_in (clk),
    .rst    (rst_a),
    .bus    (bus_a.slave)
  );

  dff_div_pipe #(
    .CLK_HZ (10),
    .OUT_HZ (5),
    .WIDTH  (4),
    .DEPTH  (1)
  ) dut_b (
    .clk_in (clk),
    .rst    (rst_b),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each record: drive rst/en/d, advance adv clk_in edges (adv=0 means wait
  // 2 time units with no edge), then compare all four outputs.
  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] d;
    int         adv;
    logic       clk_out;
    logic       tick;
    logic [3:0] q;
    logic       q_valid;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    bus_a.en = 1'b0;
    bus_a.d  = 4'h0;
    bus_b.en = 1'b0;
    bus_b.d  = 4'h0;

    //            rst   en    d     adv  clk   tick  q     qv
    // Reset held with en=1: everything stays 0.
    vecs[0]  = '{1'b0, 1'b1, 4'h1, 2,  1'b0, 1'b0, 4'h0, 1'b0};
    // Release: rise on edge 10, fall on 20, rise on 30.
    vecs[1]  = '{1'b1, 1'b1, 4'h1, 9,  1'b0, 1'b0, 4'h0, 1'b0}; // edge 9
    vecs[2]  = '{1'b1, 1'b1, 4'h1, 1,  1'b1, 1'b1, 4'h0, 1'b0}; // edge 10, tick 1 (d=1)
    vecs[3]  = '{1'b1, 1'b1, 4'hF, 1,  1'b1, 1'b0, 4'h0, 1'b0}; // edge 11
    vecs[4]  = '{1'b1, 1'b1, 4'hA, 8,  1'b1, 1'b0, 4'h0, 1'b0}; // edge 19
    vecs[5]  = '{1'b1, 1'b1, 4'h5, 1,  1'b0, 1'b0, 4'h0, 1'b0}; // edge 20, fall
    vecs[6]  = '{1'b1, 1'b1, 4'h2, 9,  1'b0, 1'b0, 4'h0, 1'b0}; // edge 29
    vecs[7]  = '{1'b1, 1'b1, 4'h2, 1,  1'b1, 1'b1, 4'h0, 1'b0}; // edge 30, tick 2 (d=2)
    vecs[8]  = '{1'b1, 1'b1, 4'h9, 19, 1'b0, 1'b0, 4'h0, 1'b0}; // edge 49
    vecs[9]  = '{1'b1, 1'b1, 4'h3, 1,  1'b1, 1'b1, 4'h1, 1'b1}; // edge 50, tick 3
    vecs[10] = '{1'b1, 1'b1, 4'h7, 19, 1'b0, 1'b0, 4'h1, 1'b1}; // edge 69
    vecs[11] = '{1'b1, 1'b1, 4'h4, 1,  1'b1, 1'b1, 4'h2, 1'b1}; // edge 70, tick 4
    // Disable for 7 cycles at cnt=5: fall slips from edge 80 to edge 87.
    vecs[12] = '{1'b1, 1'b1, 4'h5, 5,  1'b1, 1'b0, 4'h2, 1'b1}; // edge 75, cnt=5
    vecs[13] = '{1'b1, 1'b0, 4'hB, 7,  1'b1, 1'b0, 4'h2, 1'b1}; // edge 82, held
    vecs[14] = '{1'b1, 1'b1, 4'h5, 4,  1'b1, 1'b0, 4'h2, 1'b1}; // edge 86
    vecs[15] = '{1'b1, 1'b1, 4'h5, 1,  1'b0, 1'b0, 4'h2, 1'b1}; // edge 87, fall
    vecs[16] = '{1'b1, 1'b1, 4'h6, 9,  1'b0, 1'b0, 4'h2, 1'b1}; // edge 96
    vecs[17] = '{1'b1, 1'b1, 4'h6, 1,  1'b1, 1'b1, 4'h3, 1'b1}; // edge 97, tick
    vecs[18] = '{1'b1, 1'b1, 4'h8, 9,  1'b1, 1'b0, 4'h3, 1'b1}; // edge 106
    vecs[19] = '{1'b1, 1'b1, 4'h8, 1,  1'b0, 1'b0, 4'h3, 1'b1}; // edge 107
    vecs[20] = '{1'b1, 1'b1, 4'h8, 10, 1'b1, 1'b1, 4'h4, 1'b1}; // edge 117
    // Async reset mid-cycle with clk_out=1, q_valid=1: cleared without an edge.
    vecs[21] = '{1'b0, 1'b1, 4'h9, 0,  1'b0, 1'b0, 4'h0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 4'h9, 3,  1'b0, 1'b0, 4'h0, 1'b0};
    // Restart from cnt=0; q_valid needs three fresh ticks.
    vecs[23] = '{1'b1, 1'b1, 4'hC, 9,  1'b0, 1'b0, 4'h0, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 4'hC, 1,  1'b1, 1'b1, 4'h0, 1'b0}; // tick 1 (d=C)
    vecs[25] = '{1'b1, 1'b1, 4'hD, 20, 1'b1, 1'b1, 4'h0, 1'b0}; // tick 2
    vecs[26] = '{1'b1, 1'b1, 4'hE, 20, 1'b1, 1'b1, 4'hC, 1'b1}; // tick 3
    // en=0 across the would-be wrap edge suppresses it.
    vecs[27] = '{1'b1, 1'b1, 4'hE, 9,  1'b1, 1'b0, 4'hC, 1'b1}; // cnt=9
    vecs[28] = '{1'b1, 1'b0, 4'hE, 3,  1'b1, 1'b0, 4'hC, 1'b1}; // no wrap
    vecs[29] = '{1'b1, 1'b1, 4'hE, 1,  1'b0, 1'b0, 4'hC, 1'b1}; // wrap, fall

    for (int i = 0; i < NV; i++) begin
      rst_a    = vecs[i].rst;
      bus_a.en = vecs[i].en;
      bus_a.d  = vecs[i].d;
      if (vecs[i].adv == 0) begin
        #2;
      end else begin
        repeat (vecs[i].adv) step();
      end
      check($sformatf("a[%0d].clk_out", i), {3'b0, bus_a.clk_out}, {3'b0, vecs[i].clk_out});
      check($sformatf("a[%0d].tick", i),    {3'b0, bus_a.tick},    {3'b0, vecs[i].tick});
      check($sformatf("a[%0d].q", i),       bus_a.q,               vecs[i].q);
      check($sformatf("a[%0d].q_valid", i), {3'b0, bus_a.q_valid}, {3'b0, vecs[i].q_valid});
    end

    // HALF=1, DEPTH=1: clk_out toggles every enabled cycle, tick on every
    // second one, q takes d on each tick.
    check("b.reset.clk_out", {3'b0, bus_b.clk_out}, 4'h0);
    check("b.reset.q_valid", {3'b0, bus_b.q_valid}, 4'h0);
    step();
    rst_b    = 1'b1;
    bus_b.en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus_b.d = 4'(i);
      step();
      check($sformatf("b[%0d].clk_out", i), {3'b0, bus_b.clk_out}, (i % 2 == 1) ? 4'h1 : 4'h0);
      check($sformatf("b[%0d].tick", i),    {3'b0, bus_b.tick},    (i % 2 == 1) ? 4'h1 : 4'h0);
      check($sformatf("b[%0d].q", i),       bus_b.q,               (i % 2 == 1) ? 4'(i) : 4'(i - 1));
      check($sformatf("b[%0d].q_valid", i), {3'b0, bus_b.q_valid}, 4'h1);
    end
    bus_b.en = 1'b0;
    bus_b.d  = 4'hF;
    step();
    check("b.hold.clk_out", {3'b0, bus_b.clk_out}, 4'h0);
    check("b.hold.tick",    {3'b0, bus_b.tick},    4'h0);
    check("b.hold.q",       bus_b.q,               4'h5);
    bus_b.en = 1'b1;
    step();
    check("b.resume.clk_out", {3'b0, bus_b.clk_out}, 4'h1);
    check("b.resume.tick",    {3'b0, bus_b.tick},    4'h1);
    check("b.resume.q",       bus_b.q,               4'hF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
